ps2_digit_entry: RTL
====================

PS2_DIGIT_ENTRY -- requirements
Module: ps2_digit_entry

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the maximum number of buffered decimal digits (legal range 1..8).
REQ-002 The block SHALL have parameter NUMPAD_EN, default 1, meaning numeric-keypad make codes are also accepted as digits when 1.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port scan_code, input, 8, the PS/2 set-2 scan code byte.
REQ-006 The block SHALL have port scan_valid, input, 1, a one-cycle strobe qualifying scan_code.
REQ-007 The block SHALL have port digits_bcd, output, 4*NUM_DIGITS, the live buffer, most recent digit in bits [3:0].
REQ-008 The block SHALL have port digit_count, output, 4, the number of digits currently buffered.
REQ-009 The block SHALL have port entry_value, output, 4*NUM_DIGITS, the BCD value latched at the last accepted Enter.
REQ-010 The block SHALL have port entry_valid, output, 1, a one-cycle pulse when entry_value updates.
REQ-011 The block SHALL have port key_error, output, 1, a one-cycle pulse on a rejected key.

Function
REQ-012 The block SHALL process bytes only in cycles where scan_valid=1, and all outputs SHALL update on the next rising clk edge (1-cycle latency).
REQ-013 The prefix FSM SHALL have states IDLE, EXT and BRK.
- IDLE: 0xE0 goes to EXT; 0xF0 goes to BRK; any other byte is a make code processed as a key, staying in IDLE.
- EXT: 0xF0 goes to BRK; any other byte is processed as an extended key, then the FSM returns to IDLE.
- BRK: any byte is discarded (release) and the FSM returns to IDLE.
REQ-014 Digit make codes SHALL map as follows.
- Main row: 45/16/1E/26/25/2E/36/3D/3E/46 map to 0..9.
- When NUMPAD_EN=1, non-extended 70/69/72/7A/6B/73/74/6C/75/7D also map to 0..9.
- Extended bytes SHALL never decode as digits.
REQ-015 A digit with digit_count<NUM_DIGITS SHALL shift digits_bcd left 4 bits, insert the digit in [3:0], and increment digit_count.
REQ-016 A digit with digit_count=NUM_DIGITS SHALL leave the buffer unchanged and pulse key_error.
REQ-017 Backspace (0x66, non-extended) SHALL shift digits_bcd right 4 bits with zero fill and decrement digit_count; when digit_count=0 it SHALL do nothing, with no error.
REQ-018 Escape (0x76, non-extended) SHALL clear digits_bcd and digit_count to 0.
REQ-019 Enter SHALL be 0x5A, either plain or extended (keypad).
- With digit_count>0, Enter SHALL copy digits_bcd to entry_value, pulse entry_valid, and clear the buffer in the same edge.
- With digit_count=0, Enter SHALL pulse key_error and leave entry_value unchanged.
REQ-020 All other codes SHALL be ignored with no error.
REQ-021 Repeated make codes without a break (typematic) SHALL each count as a new press.
REQ-022 entry_value SHALL hold its value until the next accepted Enter or reset.
REQ-023 entry_valid and key_error SHALL never be high in the same cycle and SHALL never be high for more than one cycle per byte.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear the FSM to IDLE and drive digits_bcd=0, digit_count=0, entry_value=0, entry_valid=0 and key_error=0.
REQ-025 Reset mid-sequence (after E0 or F0) SHALL discard the pending prefix, so that the first byte after release is treated as a fresh code from IDLE.

Structure
REQ-026 Scan-code constants (prefixes, Enter, Escape, Backspace, digit codes) and the FSM state encoding SHALL reside in shared package ps2_pkg.
REQ-027 Digit decoding SHALL be a combinational sub-module ps2_scan_decode (inputs: code, extended flag, NUMPAD_EN; outputs: is_digit, digit[3:0]), instantiated once.

Verification
REQ-028 Scenario: with NUM_DIGITS=4, send 16,1E,26 then 5A -> entry_value=0x0123, entry_valid pulses once, and digit_count returns to 0.
REQ-029 Scenario: send 16,1E,26,25,2E -> the fifth digit is rejected with a key_error pulse, and digits_bcd=0x1234 with digit_count=4.
REQ-030 Scenario: send 16,F0,16,1E,F0,1E -> the buffer holds 0x0012 (break codes ignored); then 66 -> 0x0001 with count 1; then 76 -> 0 with count 0.
REQ-031 Scenario: send E0,5A with count 0 -> key_error pulses; send 69 then E0,5A -> entry_value=0x0001; with NUMPAD_EN=0, 69 is ignored.
REQ-032 Scenario: send E0,70 -> the buffer is unchanged, since an extended byte is not a digit.
REQ-033 Scenario: send E0, then assert rst_n low, then release and send 16 -> digits_bcd=0x0001; and scan_code 16 presented with scan_valid=0 -> no change.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 set-2 scan-code constants and prefix FSM encoding
package ps2_pkg;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [9:0][7:0] MAIN_CODES = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  localparam logic [9:0][7:0] PAD_CODES  = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};
  typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;
endpackage

// File: rtl/ps2_scan_decode.sv
// ps2_scan_decode: combinational make-code to decimal digit decoder
module ps2_scan_decode
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       numpad_en,
  output logic       is_digit,
  output logic [3:0] digit
);
  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    for (int i = 0; i < 10; i++)
      if (!ext && (code == MAIN_CODES[i] || (numpad_en && code == PAD_CODES[i]))) begin
        is_digit = 1'b1;
        digit    = 4'(i);
      end
  end
endmodule

// File: rtl/ps2_digit_entry.sv
// ps2_digit_entry: PS/2 keyboard decimal digit entry buffer with backspace, escape and enter
module ps2_digit_entry
  import ps2_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit NUMPAD_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              scan_code,
  input  logic                    scan_valid,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [3:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] entry_value,
  output logic                    entry_valid,
  output logic                    key_error
);
  localparam int W = 4 * NUM_DIGITS;
  state_t st, st_n;
  logic is_digit, ext, prefix, is_key, full, ev_n, ke_n;
  logic [3:0] digit, cnt_n;
  logic [W-1:0] buf_n, ent_n;
  assign ext    = st == EXT;
  assign prefix = (st == IDLE && scan_code == PFX_EXT) || (st != BRK && scan_code == PFX_BRK);
  assign is_key = scan_valid && st != BRK && !prefix;
  assign full   = digit_count >= 4'(NUM_DIGITS);
  ps2_scan_decode u_dec (
    .code      (scan_code),
    .ext       (ext),
    .numpad_en (NUMPAD_EN),
    .is_digit  (is_digit),
    .digit     (digit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st          <= IDLE;
      digits_bcd  <= '0;
      digit_count <= '0;
      entry_value <= '0;
      entry_valid <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      st          <= st_n;
      digits_bcd  <= buf_n;
      digit_count <= cnt_n;
      entry_value <= ent_n;
      entry_valid <= ev_n;
      key_error   <= ke_n;
    end
  always_comb begin
    st_n  = !scan_valid ? st :
            st == BRK ? IDLE :
            scan_code == PFX_BRK ? BRK :
            (st == IDLE && scan_code == PFX_EXT) ? EXT : IDLE;
    buf_n = digits_bcd;
    cnt_n = digit_count;
    ent_n = entry_value;
    ev_n  = 1'b0;
    ke_n  = 1'b0;
    if (is_key) begin
      if (is_digit) begin
        ke_n  = full;
        buf_n = full ? digits_bcd : (digits_bcd << 4) | W'(digit);
        cnt_n = full ? digit_count : digit_count + 4'd1;
      end else if (!ext && scan_code == KEY_BKSP) begin
        buf_n = digits_bcd >> 4;
        cnt_n = digit_count == 4'd0 ? digit_count : digit_count - 4'd1;
      end else if (!ext && scan_code == KEY_ESC) begin
        buf_n = '0;
        cnt_n = '0;
      end else if (scan_code == KEY_ENTER) begin
        ke_n = digit_count == 4'd0;
        ev_n = digit_count != 4'd0;
        if (digit_count != 4'd0) begin
          ent_n = digits_bcd;
          buf_n = '0;
          cnt_n = '0;
        end
      end
    end
  end
endmodule
